// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer width default and Gray/binary conversion helpers.
// Helpers work on any width up to MAX_BITS; callers zero-extend and truncate.
package fifo_pkg;
    localparam int NUM_BITS_DEF = 4;
    localparam int MAX_BITS = 32;
    function automatic logic [MAX_BITS-1:0] gray2bin(input logic [MAX_BITS-1:0] g);
        logic [MAX_BITS-1:0] b;
        b = g;
        for (int i = MAX_BITS - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
    function automatic logic [MAX_BITS-1:0] bin2gray(input logic [MAX_BITS-1:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/gray_sync.sv
// gray_sync: multi-flop synchronizer bringing a Gray-coded pointer into clk.
module gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] sr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) sr <= '0;
        else sr <= {sr[STAGES-2:0], d};
    assign q = sr[STAGES-1];
endmodule

// File: rtl/fifo_full_flag.sv
// fifo_full_flag: write-side full/almost_full/level flags of an async FIFO.
// Flags are computed from the next write pointer so full rises on the filling write.
module fifo_full_flag
    import fifo_pkg::*;
#(
    parameter int NUM_BITS    = NUM_BITS_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 2 ** (NUM_BITS - 1) - 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic [NUM_BITS-1:0] wr_gray,
    input  logic [NUM_BITS-1:0] rd_gray_async,
    output logic                full,
    output logic                almost_full,
    output logic [NUM_BITS-1:0] wr_level,
    output logic [NUM_BITS-1:0] rd_gray_sync
);
    // full when the two top Gray bits differ and the rest match
    localparam logic [NUM_BITS-1:0] FULL_MASK = NUM_BITS'(3) << (NUM_BITS - 2);
    logic                accept;
    logic [NUM_BITS-1:0] wr_bin;
    logic [NUM_BITS-1:0] rd_bin;
    logic [NUM_BITS-1:0] wr_bin_next;
    logic [NUM_BITS-1:0] wr_gray_next;
    logic [NUM_BITS-1:0] level_next;
    gray_sync #(.WIDTH(NUM_BITS), .STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rd_gray_async),
        .q  (rd_gray_sync)
    );
    assign accept       = inc & ~full;
    assign wr_bin       = NUM_BITS'(gray2bin(MAX_BITS'(wr_gray)));
    assign rd_bin       = NUM_BITS'(gray2bin(MAX_BITS'(rd_gray_sync)));
    assign wr_bin_next  = wr_bin + NUM_BITS'(accept);
    assign wr_gray_next = NUM_BITS'(bin2gray(MAX_BITS'(wr_bin_next)));
    assign level_next   = wr_bin_next - rd_bin;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            full        <= wr_gray_next == (rd_gray_sync ^ FULL_MASK);
            almost_full <= 32'(level_next) >= AF_THRESH;
            wr_level    <= level_next;
        end
endmodule
